// File: rtl/regfile_param_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_param_if
// Brief   : Read, write and bulk-clear bus of the parametrised register file.
// Rev     : 1.0  initial release
// ============================================================================
interface regfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1_i;
    logic [ADDR_W-1:0] rd_addr2_i;
    logic [WIDTH-1:0]  rd_data1_o;
    logic [WIDTH-1:0]  rd_data2_o;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [WIDTH-1:0]  wr_data_i;
    logic              wr_ack_o;
    logic              clear_i;
    logic              busy_o;

    modport master (
        output rd_addr1_i, rd_addr2_i, wr_en_i, wr_addr_i, wr_data_i, clear_i,
        input  rd_data1_o, rd_data2_o, wr_ack_o, busy_o
    );

    modport slave (
        input  rd_addr1_i, rd_addr2_i, wr_en_i, wr_addr_i, wr_data_i, clear_i,
        output rd_data1_o, rd_data2_o, wr_ack_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module  : regfile_param
// Brief   : 2R/1W register file with write bypass, hardwired zero register
//           and a one-register-per-cycle bulk-clear sequencer.
// Rev     : 1.0  initial release
// ============================================================================
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    regfile_param_if.slave    bus
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       c_DEPTH32  = 32'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [ADDR_W-1:0] w_clrCntNext;
    logic              w_busy;
    logic              w_wrAck;

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]  w_wrHit;
    logic [DEPTH-1:0]  w_clrHit;

    logic [WIDTH-1:0]  w_stored1;
    logic [WIDTH-1:0]  w_stored2;
    logic              w_zero1;
    logic              w_zero2;
    logic              w_byp1;
    logic              w_byp2;

    // Addresses above DEPTH-1 are unbacked; compare in 32 bits so that
    // DEPTH == 2**ADDR_W does not overflow the address width.
    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < c_DEPTH32);
    endfunction

    // ------------------------------------------------------------------
    // Bulk-clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_clrCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_clrCnt <= w_clrCntNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_clrCntNext = r_clrCnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear_i) begin
                    w_stateNext  = ST_CLEAR;
                    w_clrCntNext = '0;
                end
            end
            ST_CLEAR: begin
                // Counter parks on the last index instead of wrapping.
                if (r_clrCnt == c_LAST_IDX) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_clrCntNext = r_clrCnt + 1'b1;
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_clrCntNext = '0;
            end
        endcase
    end

    assign w_busy = (r_state == ST_CLEAR);

    // ------------------------------------------------------------------
    // Write acceptance and per-register decode
    // ------------------------------------------------------------------
    assign w_wrAck = bus.wr_en_i && !w_busy && inRange(bus.wr_addr_i)
                   && !((ZERO_REG != 0) && (bus.wr_addr_i == '0));

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
        assign w_wrHit[gi]  = w_wrAck && (bus.wr_addr_i == ADDR_W'(gi));
        assign w_clrHit[gi] = w_busy  && (r_clrCnt == ADDR_W'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clrHit[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wrHit[i]) begin
                    r_regs[i] <= bus.wr_data_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr1_i == ADDR_W'(i)) begin
                w_stored1 = r_regs[i];
            end
            if (bus.rd_addr2_i == ADDR_W'(i)) begin
                w_stored2 = r_regs[i];
            end
        end
    end

    assign w_zero1 = !inRange(bus.rd_addr1_i) || ((ZERO_REG != 0) && (bus.rd_addr1_i == '0));
    assign w_zero2 = !inRange(bus.rd_addr2_i) || ((ZERO_REG != 0) && (bus.rd_addr2_i == '0));

    // Bypass is held off while in reset so reads return 0 regardless of the write port.
    assign w_byp1 = (BYPASS != 0) && rst_i && w_wrAck && (bus.rd_addr1_i == bus.wr_addr_i);
    assign w_byp2 = (BYPASS != 0) && rst_i && w_wrAck && (bus.rd_addr2_i == bus.wr_addr_i);

    assign bus.rd_data1_o = w_zero1 ? '0 : (w_byp1 ? bus.wr_data_i : w_stored1);
    assign bus.rd_data2_o = w_zero2 ? '0 : (w_byp2 ? bus.wr_data_i : w_stored2);
    assign bus.wr_ack_o   = w_wrAck;
    assign bus.busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_param
// Brief   : Self-checking bench for regfile_param (DEPTH 32 and DEPTH 24).
// Rev     : 1.0  initial release
// ============================================================================
module tb_regfile_param;

    localparam int c_DEP [2] = '{32, 24};
    localparam int c_NONE    = -100000;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    always #5 clk = ~clk;

    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) busA ();
    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) busB ();

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        dutA (.clk_i(clk), .rst_i(rstA), .bus(busA));
    regfile_param #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        dutB (.clk_i(clk), .rst_i(rstB), .bus(busB));

    int nTests;
    int nFail;
    int ecnt;
    int cs [2];
    logic [31:0] mem [2][32];

    logic [4:0]  ra1 [2];
    logic [4:0]  ra2 [2];
    logic [4:0]  wa  [2];
    logic [31:0] wd  [2];
    logic        wen [2];
    logic        clr [2];

    logic [31:0] sRd1 [2];
    logic [31:0] sRd2 [2];
    logic        sAck [2];
    logic        sBusy[2];
    logic        pB [2];
    logic        pK [2];

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eAck;
    } vec_t;
    vec_t tbl [7];

    // Reference model: a clear accepted on edge cs zeroes register k on edge cs+1+k.
    function automatic logic busyM(int d);
        int t;
        t = ecnt - cs[d];
        return (t >= 0) && (t < c_DEP[d]);
    endfunction

    function automatic logic ackM(int d);
        return wen[d] && !busyM(d) && (int'(wa[d]) < c_DEP[d]) && (wa[d] != 5'd0);
    endfunction

    function automatic logic [31:0] readM(int d, logic [4:0] a);
        if (int'(a) >= c_DEP[d] || a == 5'd0) return 32'h0;
        if (ackM(d) && a == wa[d]) return wd[d];
        return mem[d][a];
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            ra1[d] = 5'd0; ra2[d] = 5'd0; wa[d] = 5'd0;
            wd[d]  = 32'h0; wen[d] = 1'b0; clr[d] = 1'b0;
        end
    endtask

    task automatic applyInputs();
        busA.rd_addr1_i = ra1[0]; busA.rd_addr2_i = ra2[0];
        busA.wr_en_i    = wen[0]; busA.wr_addr_i  = wa[0];
        busA.wr_data_i  = wd[0];  busA.clear_i    = clr[0];
        busB.rd_addr1_i = ra1[1]; busB.rd_addr2_i = ra2[1];
        busB.wr_en_i    = wen[1]; busB.wr_addr_i  = wa[1];
        busB.wr_data_i  = wd[1];  busB.clear_i    = clr[1];
    endtask

    task automatic sample();
        sRd1[0] = busA.rd_data1_o; sRd2[0] = busA.rd_data2_o;
        sAck[0] = busA.wr_ack_o;   sBusy[0] = busA.busy_o;
        sRd1[1] = busB.rd_data1_o; sRd2[1] = busB.rd_data2_o;
        sAck[1] = busB.wr_ack_o;   sBusy[1] = busB.busy_o;
    endtask

    task automatic resetModel(int d);
        for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
        cs[d] = c_NONE;
    endtask

    // First half of a cycle: drive, then compare everything against the model.
    task automatic tickPre();
        applyInputs();
        @(negedge clk);
        sample();
        for (int d = 0; d < 2; d++) begin
            pB[d] = busyM(d);
            pK[d] = ackM(d);
            check($sformatf("model rd1 dut%0d a=%0d", d, ra1[d]), sRd1[d], readM(d, ra1[d]));
            check($sformatf("model rd2 dut%0d a=%0d", d, ra2[d]), sRd2[d], readM(d, ra2[d]));
            check($sformatf("model ack dut%0d", d), 32'(sAck[d]), 32'(pK[d]));
            check($sformatf("model busy dut%0d", d), 32'(sBusy[d]), 32'(pB[d]));
        end
    endtask

    task automatic tickPost();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pB[d]) begin
                mem[d][ecnt - cs[d]] = 32'h0;
            end else begin
                if (pK[d]) mem[d][wa[d]] = wd[d];
                if (clr[d]) cs[d] = ecnt + 1;
            end
        end
        ecnt++;
        #1;
    endtask

    task automatic tick();
        tickPre();
        tickPost();
    endtask

    initial begin
        int busyCnt;
        nTests = 0;
        nFail  = 0;
        ecnt   = 0;
        resetModel(0);
        resetModel(1);
        idle();
        applyInputs();
        rstA = 1'b0;
        rstB = 1'b0;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1};
        tbl[1] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        tbl[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0,        1'b1};
        tbl[5] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31, 32'h11111111, 32'hA5A5A5A5, 1'b1};
        tbl[6] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'h11111111, 32'h11111111, 1'b0};

        // Reads while held in reset
        #2;
        for (int a = 0; a < 32; a++) begin
            ra1[0] = 5'(a);
            ra2[0] = 5'(31 - a);
            applyInputs();
            #1;
            check($sformatf("reset rd1 a=%0d", a), busA.rd_data1_o, 32'h0);
            check($sformatf("reset rd2 a=%0d", a), busA.rd_data2_o, 32'h0);
        end
        check("reset busy", 32'(busA.busy_o), 32'h0);
        @(posedge clk);
        #1;
        rstA = 1'b1;
        rstB = 1'b1;

        // Directed vectors: bypass, zero register, store-after-write
        for (int i = 0; i < 7; i++) begin
            idle();
            wen[0] = tbl[i].wen; wa[0] = tbl[i].wa; wd[0] = tbl[i].wd;
            ra1[0] = tbl[i].ra1; ra2[0] = tbl[i].ra2;
            tickPre();
            check($sformatf("tbl%0d rd1", i), sRd1[0], tbl[i].e1);
            check($sformatf("tbl%0d rd2", i), sRd2[0], tbl[i].e2);
            check($sformatf("tbl%0d ack", i), 32'(sAck[0]), 32'(tbl[i].eAck));
            tickPost();
        end

        // Fill r1..r31 with their index, then bulk clear
        for (int i = 1; i < 32; i++) begin
            idle();
            wen[0] = 1'b1; wa[0] = 5'(i); wd[0] = 32'(i);
            ra1[0] = 5'(i); ra2[0] = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        clr[0] = 1'b1;
        tick();
        busyCnt = 0;
        for (int j = 0; j < 36; j++) begin
            idle();
            if (j == 5) begin
                wen[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hAA;
            end
            ra1[0] = 5'(j % 32);
            tickPre();
            if (sBusy[0]) busyCnt++;
            if (j == 5) check("write while busy ack", 32'(sAck[0]), 32'h0);
            tickPost();
        end
        check("busy cycle count", 32'(busyCnt), 32'd32);
        for (int a = 0; a < 32; a++) begin
            idle();
            ra1[0] = 5'(a); ra2[0] = 5'(31 - a);
            tickPre();
            check($sformatf("post-clear rd1 a=%0d", a), sRd1[0], 32'h0);
            check($sformatf("post-clear rd2 a=%0d", a), sRd2[0], 32'h0);
            tickPost();
        end

        // Write and clear on the same edge: the write lands, then gets wiped
        idle();
        wen[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h55; clr[0] = 1'b1; ra1[0] = 5'd7;
        tickPre();
        check("wr+clr ack", 32'(sAck[0]), 32'h1);
        check("wr+clr bypass", sRd1[0], 32'h55);
        tickPost();
        for (int j = 0; j < 34; j++) begin
            idle();
            ra1[0] = 5'd7;
            tickPre();
            check($sformatf("r7 during clear j=%0d", j), sRd1[0], (j <= 7) ? 32'h55 : 32'h0);
            tickPost();
        end

        // DEPTH=24 instance: out-of-range access, then reset mid-clear
        idle();
        wen[1] = 1'b1; wa[1] = 5'd30; wd[1] = 32'hCAFEF00D; ra1[1] = 5'd30;
        tickPre();
        check("oob write ack", 32'(sAck[1]), 32'h0);
        check("oob read", sRd1[1], 32'h0);
        tickPost();
        idle();
        wen[1] = 1'b1; wa[1] = 5'd23; wd[1] = 32'h0BADBEEF; ra1[1] = 5'd23;
        tickPre();
        check("last reg ack", 32'(sAck[1]), 32'h1);
        check("last reg bypass", sRd1[1], 32'h0BADBEEF);
        tickPost();
        idle();
        wen[1] = 1'b1; wa[1] = 5'd20; wd[1] = 32'h13572468;
        tick();
        idle();
        clr[1] = 1'b1;
        tick();
        for (int j = 0; j < 10; j++) begin
            idle();
            ra1[1] = 5'd23; ra2[1] = 5'd20;
            tick();
        end
        check("B busy before abort", 32'(busB.busy_o), 32'h1);
        rstB = 1'b0;
        #1;
        check("abort busy", 32'(busB.busy_o), 32'h0);
        check("abort rd1 r23", busB.rd_data1_o, 32'h0);
        check("abort rd2 r20", busB.rd_data2_o, 32'h0);
        resetModel(1);
        idle();
        tick();
        tick();
        rstB = 1'b1;
        for (int a = 0; a < 32; a++) begin
            idle();
            ra1[1] = 5'(a); ra2[1] = 5'(31 - a);
            tickPre();
            check($sformatf("B after abort rd1 a=%0d", a), sRd1[1], 32'h0);
            check($sformatf("B after abort rd2 a=%0d", a), sRd2[1], 32'h0);
            tickPost();
        end

        // Random traffic on both instances against the model
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                wen[d] = 1'($urandom_range(0, 1));
                wa[d]  = 5'($urandom_range(0, 31));
                wd[d]  = $urandom;
                ra1[d] = ($urandom_range(0, 2) == 0) ? wa[d] : 5'($urandom_range(0, 31));
                ra2[d] = 5'($urandom_range(0, 31));
                clr[d] = ($urandom_range(0, 49) == 0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
